// File: rtl/rr_grant_pkg.sv
// Shared types and width helpers for the round-robin grant controller.
package rr_grant_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Keeps a 1-bit pointer legal even for a degenerate single-requester build.
    function automatic int ptr_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/rr_ffs_from_pos.sv
// Rotating find-first-set: lowest set bit of x at index >= pos, wrapping past W-1 to 0.
module rr_ffs_from_pos
    import rr_grant_pkg::*;
#(
    parameter  int W  = 8,
    localparam int PW = ptr_width(W)
) (
    input  logic [W-1:0]  x,
    input  logic [PW-1:0] pos,
    output logic          any,
    output logic [W-1:0]  y,
    output logic [PW-1:0] y_enc
);

    logic [PW-1:0] w_idx;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        any   = 1'b0;
        y     = '0;
        y_enc = '0;
        w_idx = '0;
        for (int i = 0; i < W; i++) begin
            // W is a power of two, so the pointer add wraps naturally.
            w_idx = pos + i[PW-1:0];
            if (!any && x[w_idx]) begin
                any      = 1'b1;
                y[w_idx] = 1'b1;
                y_enc    = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: holds one multi-beat grant at a time, re-arbitrates on
// completion without a bubble, and forces release after P_MAX_BEATS accepted beats.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter  int W           = 8,
    parameter  int P_MAX_BEATS = 16,
    localparam int P_CNT_W     = cnt_width(P_MAX_BEATS),
    localparam int PW          = ptr_width(W)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic [W-1:0]  req_i,
    input  logic [W-1:0]  last_i,
    input  logic          ack_i,
    output logic          gnt_vld_o,
    output logic [W-1:0]  gnt_o,
    output logic [PW-1:0] gnt_enc_o,
    output logic [PW-1:0] ptr_o,
    output logic          forced_o
);

    localparam logic [P_CNT_W-1:0] LP_LAST_BEAT = P_CNT_W'(P_MAX_BEATS - 1);

    state_t               r_state, w_state_nxt;
    logic [PW-1:0]        r_ptr, w_ptr_nxt;
    logic [W-1:0]         r_gnt, w_gnt_nxt;
    logic [PW-1:0]        r_gnt_enc, w_gnt_enc_nxt;
    logic [P_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_forced, w_forced_nxt;

    logic [W-1:0]         w_search_vec;
    logic [PW-1:0]        w_search_pos;
    logic [PW-1:0]        w_enc_inc;
    logic                 w_any;
    logic [W-1:0]         w_win;
    logic [PW-1:0]        w_win_enc;
    logic                 w_done_norm;
    logic                 w_done_force;
    logic                 w_done;
    logic                 w_drop;

    assign w_enc_inc    = r_gnt_enc + PW'(1);
    assign w_done_norm  = ack_i & last_i[r_gnt_enc];
    assign w_done_force = ack_i & (r_cnt == LP_LAST_BEAT);
    assign w_done       = w_done_norm | w_done_force;
    assign w_drop       = ~req_i[r_gnt_enc];

    // In BUSY the current holder is masked so it can never win on its own completing cycle.
    assign w_search_vec = (r_state == BUSY) ? (req_i & ~r_gnt) : req_i;
    assign w_search_pos = (r_state == BUSY) ? w_enc_inc : r_ptr;

    rr_ffs_from_pos #(
        .W (W)
    ) u_ffs (
        .x     (w_search_vec),
        .pos   (w_search_pos),
        .any   (w_any),
        .y     (w_win),
        .y_enc (w_win_enc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_gnt_enc_nxt = r_gnt_enc;
        w_cnt_nxt     = r_cnt;
        w_forced_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt   = BUSY;
                    w_gnt_nxt     = w_win;
                    w_gnt_enc_nxt = w_win_enc;
                    w_cnt_nxt     = '0;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_ptr_nxt    = w_enc_inc;
                    w_cnt_nxt    = '0;
                    // A genuine last beat on the limit beat is a normal completion.
                    w_forced_nxt = w_done_force & ~w_done_norm;
                    if (w_any) begin
                        w_gnt_nxt     = w_win;
                        w_gnt_enc_nxt = w_win_enc;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_gnt_nxt     = '0;
                        w_gnt_enc_nxt = '0;
                    end
                end else if (w_drop) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = w_enc_inc;
                    w_cnt_nxt     = '0;
                    w_gnt_nxt     = '0;
                    w_gnt_enc_nxt = '0;
                end else if (ack_i) begin
                    w_cnt_nxt = r_cnt + P_CNT_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_enc <= '0;
            r_cnt     <= '0;
            r_forced  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_enc <= w_gnt_enc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_forced  <= w_forced_nxt;
        end
    end

    assign gnt_vld_o = (r_state == BUSY);
    assign gnt_o     = r_gnt;
    assign gnt_enc_o = r_gnt_enc;
    assign ptr_o     = r_ptr;
    assign forced_o  = r_forced;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl (W=8, P_MAX_BEATS=4): vector table plus scoreboard queue.
module tb_rr_grant_ctrl;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] req_i;
    logic [7:0] last_i;
    logic       ack_i;
    logic       gnt_vld_o;
    logic [7:0] gnt_o;
    logic [2:0] gnt_enc_o;
    logic [2:0] ptr_o;
    logic       forced_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] last;
        logic       ack;
        logic       vld;
        logic [2:0] enc;
        logic [2:0] ptr;
        logic       forced;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [2:0] enc;
        logic [2:0] ptr;
        logic       forced;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   step_id = 0;

    rr_grant_ctrl #(
        .W           (8),
        .P_MAX_BEATS (4)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_i     (req_i),
        .last_i    (last_i),
        .ack_i     (ack_i),
        .gnt_vld_o (gnt_vld_o),
        .gnt_o     (gnt_o),
        .gnt_enc_o (gnt_enc_o),
        .ptr_o     (ptr_o),
        .forced_o  (forced_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] req, input logic [7:0] last, input logic ack,
                                input logic vld, input logic [2:0] enc, input logic [2:0] ptr,
                                input logic forced);
        vec_t v;
        v.req = req; v.last = last; v.ack = ack;
        v.vld = vld; v.enc = enc; v.ptr = ptr; v.forced = forced;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ".vld"},    32'(gnt_vld_o), 32'd0);
        check({tag, ".gnt"},    32'(gnt_o),     32'd0);
        check({tag, ".enc"},    32'(gnt_enc_o), 32'd0);
        check({tag, ".ptr"},    32'(ptr_o),     32'd0);
        check({tag, ".forced"}, 32'(forced_o),  32'd0);
    endtask

    task automatic compare_head();
        exp_t       e;
        logic [7:0] exp_gnt;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        exp_gnt = e.vld ? (8'b1 << e.enc) : 8'h00;
        check($sformatf("s%0d.vld", e.id),    32'(gnt_vld_o), 32'(e.vld));
        check($sformatf("s%0d.gnt", e.id),    32'(gnt_o),     32'(exp_gnt));
        check($sformatf("s%0d.enc", e.id),    32'(gnt_enc_o), 32'(e.vld ? e.enc : 3'd0));
        check($sformatf("s%0d.ptr", e.id),    32'(ptr_o),     32'(e.ptr));
        check($sformatf("s%0d.forced", e.id), 32'(forced_o),  32'(e.forced));
    endtask

    // Drives one cycle of inputs, queues the expected post-edge outputs, then compares.
    task automatic step(input vec_t v);
        exp_t e;
        req_i  = v.req;
        last_i = v.last;
        ack_i  = v.ack;
        e.vld = v.vld; e.enc = v.enc; e.ptr = v.ptr; e.forced = v.forced; e.id = step_id;
        sb.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        // Two grants back-to-back, then idle.
        vecs.push_back(mk(8'h24, 8'hFF, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0));
        vecs.push_back(mk(8'h24, 8'hFF, 1'b1, 1'b1, 3'd5, 3'd3, 1'b0));
        vecs.push_back(mk(8'h20, 8'hFF, 1'b1, 1'b0, 3'd0, 3'd6, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0));
        // Requester 7, 3-beat transfers, repeated; ack while idle is ignored.
        vecs.push_back(mk(8'h80, 8'h00, 1'b0, 1'b1, 3'd7, 3'd6, 1'b0));
        vecs.push_back(mk(8'h80, 8'h00, 1'b1, 1'b1, 3'd7, 3'd6, 1'b0));
        vecs.push_back(mk(8'h80, 8'h00, 1'b1, 1'b1, 3'd7, 3'd6, 1'b0));
        vecs.push_back(mk(8'h80, 8'h80, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0));
        vecs.push_back(mk(8'h80, 8'h00, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0));
        vecs.push_back(mk(8'h80, 8'h00, 1'b1, 1'b1, 3'd7, 3'd0, 1'b0));
        vecs.push_back(mk(8'h80, 8'h00, 1'b1, 1'b1, 3'd7, 3'd0, 1'b0));
        vecs.push_back(mk(8'h80, 8'h80, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0));
        vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0));
        // Requester 1 never sends last; forced release after 4th ack, grant moves to 3.
        vecs.push_back(mk(8'h0A, 8'h08, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b1, 1'b1, 3'd3, 3'd2, 1'b1));
        vecs.push_back(mk(8'h0A, 8'h08, 1'b1, 1'b1, 3'd1, 3'd4, 1'b0));
        vecs.push_back(mk(8'h02, 8'h02, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0));
        // Holder 6 drops req without last; then completion with a new same-cycle request.
        vecs.push_back(mk(8'h41, 8'h00, 1'b0, 1'b1, 3'd6, 3'd2, 1'b0));
        vecs.push_back(mk(8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0));
        vecs.push_back(mk(8'h01, 8'h00, 1'b0, 1'b1, 3'd0, 3'd7, 1'b0));
        vecs.push_back(mk(8'h05, 8'h01, 1'b1, 1'b1, 3'd2, 3'd1, 1'b0));
        vecs.push_back(mk(8'h04, 8'h04, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0));

        arst_n = 1'b0;
        req_i  = 8'h00;
        last_i = 8'h00;
        ack_i  = 1'b0;
        #12;
        check_idle_outputs("reset");
        arst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // All requesting, single-beat grants: rotation 0..7 then wrap to 0.
        arst_n = 1'b0;
        #2;
        check_idle_outputs("reset2");
        arst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(mk(8'hFF, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 3'(k % 8), 1'b0));
        end
        step(mk(8'h02, 8'h02, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0));
        step(mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0));

        // Reset mid-transfer with grant to 4; beat count must not survive.
        step(mk(8'h10, 8'h00, 1'b0, 1'b1, 3'd4, 3'd2, 1'b0));
        step(mk(8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 3'd2, 1'b0));
        #2;
        arst_n = 1'b0;
        #1;
        check_idle_outputs("midreset_async");
        @(posedge clk);
        #1;
        check_idle_outputs("midreset_held");
        arst_n = 1'b1;
        step(mk(8'h10, 8'h00, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0));
        step(mk(8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0));
        step(mk(8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0));
        step(mk(8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 3'd0, 1'b0));
        step(mk(8'h10, 8'h00, 1'b1, 1'b0, 3'd0, 3'd5, 1'b1));
        step(mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0));

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
